mdr_queue: RTL and testbench

- Parametrised memory data register queue for the instruction fetch stage.
- Sits between instruction memory read data and the instruction register.
- Captures up to DEPTH fetched words in arrival order and hands them to decode one per accepted read.
- Adds occupancy tracking, a flush for branch redirect, and sticky overflow/underflow error flags.

---
 rtl/mdr_queue.sv | 87 ++++++++
 tb/tb_mdr_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdr_queue.sv
// Fetch-side instruction FIFO between imem read data and the instruction register.
// One-cycle read latency (inst/inst_valid registered); writes are dropped when full unless a read frees a slot.
module mdr_queue #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MDR_wr,
  input  logic [DATA_WIDTH-1:0]        instin,
  input  logic                         MDR_rd,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        inst,
  output logic                         inst_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A read on a full queue frees the slot the same-cycle write lands in.
  assign rd_acc = MDR_rd & ~empty & ~flush;
  assign wr_acc = MDR_wr & (~full | rd_acc) & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= instin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst       <= RESET_VALUE;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= rd_acc;
      if (rd_acc) inst <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (MDR_wr && full && !rd_acc && !flush) overflow  <= 1'b1;
      if (MDR_rd && empty && !flush)           underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdr_queue.sv
// Scoreboard bench for mdr_queue: reference FIFO model predicts read data, occupancy and error flags.
module tb_mdr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDR_wr;
  logic [31:0] instin;
  logic        MDR_rd;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int passed = 0;
  int total  = 0;

  logic [31:0] store_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_inst;
  bit          m_ovf;
  bit          m_udf;
  bit          m_valid;

  always #5 clk = ~clk;

  mdr_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .MDR_wr(MDR_wr), .instin(instin), .MDR_rd(MDR_rd),
    .flush(flush), .inst(inst), .inst_valid(inst_valid), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Drive one cycle of stimulus and advance the reference model.
  task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    bit fm, em, ra, wa;
    MDR_wr = wr; instin = d; MDR_rd = rd; flush = fl;
    fm = (store_q.size() == 4);
    em = (store_q.size() == 0);
    ra = rd && !em && !fl;
    wa = wr && (!fm || ra) && !fl;
    if (wr && fm && !ra && !fl) m_ovf = 1'b1;
    if (rd && em && !fl) m_udf = 1'b1;
    if (fl) store_q.delete();
    if (ra) exp_q.push_back(store_q.pop_front());
    if (wa) store_q.push_back(d);
    m_valid = ra;
    @(posedge clk); #1;
    MDR_wr = 1'b0; MDR_rd = 1'b0; flush = 1'b0; instin = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    store_q.delete(); exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; last_inst = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_flags: got ovf=%b udf=%b want 0/0", overflow, underflow); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] e;
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    total++; if (full !== 1'b1 || count !== 3'd4)
      $display("FAIL fill_full: got full=%b count=%0d want 1/4", full, count); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      e = exp_q.pop_front(); last_inst = e;
      total++; if (inst_valid !== 1'b1 || inst !== e)
        $display("FAIL drain%0d: got inst=%h vld=%b want %h vld=1", i, inst, inst_valid, e); else passed++;
    end
    total++; if (empty !== 1'b1 || count !== 3'd0)
      $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", empty, count); else passed++;
  endtask

  task automatic test_full_rw();
    logic [31:0] e;
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hB000_0005, 1'b1, 1'b0);
    e = exp_q.pop_front(); last_inst = e;
    total++; if (inst_valid !== 1'b1 || inst !== e)
      $display("FAIL fullrw_inst: got inst=%h vld=%b want %h vld=1", inst, inst_valid, e); else passed++;
    total++; if (count !== 3'd4 || overflow !== 1'b0)
      $display("FAIL fullrw_count: got count=%0d ovf=%b want 4/0", count, overflow); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      e = exp_q.pop_front(); last_inst = e;
      total++; if (inst_valid !== 1'b1 || inst !== e)
        $display("FAIL fullrw_drain%0d: got inst=%h vld=%b want %h vld=1", i, inst, inst_valid, e); else passed++;
    end
  endtask

  task automatic test_ovf_udf();
    logic [31:0] e;
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
    total++; if (overflow !== m_ovf || count !== 3'(store_q.size()))
      $display("FAIL ovf_set: got ovf=%b count=%0d want %b/%0d", overflow, count, m_ovf, store_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      e = exp_q.pop_front(); last_inst = e;
      total++; if (inst_valid !== 1'b1 || inst !== e)
        $display("FAIL ovf_drain%0d: got inst=%h vld=%b want %h vld=1", i, inst, inst_valid, e); else passed++;
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (underflow !== m_udf || inst_valid !== 1'b0 || inst !== last_inst)
      $display("FAIL udf_set: got udf=%b vld=%b inst=%h want %b/0/%h", underflow, inst_valid, inst, m_udf, last_inst); else passed++;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1 || underflow !== 1'b1)
      $display("FAIL flags_sticky: got ovf=%b udf=%b want 1/1", overflow, underflow); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] e;
    for (int i = 1; i <= 3; i++) step(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    e = exp_q.pop_front(); last_inst = e;
    total++; if (inst !== e) $display("FAIL flush_pre: got inst=%h want %h", inst, e); else passed++;
    step(1'b1, 32'hF000_0004, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    total++; if (count !== 3'd0 || empty !== 1'b1)
      $display("FAIL flush_count: got count=%0d empty=%b want 0/1", count, empty); else passed++;
    total++; if (inst !== last_inst || inst_valid !== 1'b0)
      $display("FAIL flush_inst: got inst=%h vld=%b want %h/0", inst, inst_valid, last_inst); else passed++;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL flush_flags: got ovf=%b udf=%b want 0/0", overflow, underflow); else passed++;
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    e = exp_q.pop_front(); last_inst = e;
    total++; if (inst_valid !== 1'b1 || inst !== e)
      $display("FAIL flush_after: got inst=%h vld=%b want %h vld=1", inst, inst_valid, e); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      e = exp_q.pop_front(); last_inst = e;
      total++; if (inst_valid !== 1'b1 || inst !== e)
        $display("FAIL wrap%0d: got inst=%h vld=%b want %h vld=1", i, inst, inst_valid, e); else passed++;
    end
    // Overlapped traffic keeps one entry in flight across further wraps.
    step(1'b1, 32'h5555_0000, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 32'h5555_0000 + 32'(i), 1'b1, 1'b0);
      e = exp_q.pop_front(); last_inst = e;
      total++; if (inst_valid !== 1'b1 || inst !== e || count !== 3'(store_q.size()))
        $display("FAIL wrap_rw%0d: got inst=%h vld=%b cnt=%0d want %h/1/%0d", i, inst, inst_valid, count, e, store_q.size()); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h7777_0001, 1'b0, 1'b0);
    step(1'b1, 32'h7777_0002, 1'b0, 1'b0);
    MDR_wr = 1'b1; instin = 32'h9999_9999; MDR_rd = 1'b1;
    do_reset();
    MDR_wr = 1'b0; MDR_rd = 1'b0; instin = 32'h0;
    total++; if (count !== 3'd0 || empty !== 1'b1)
      $display("FAIL rstmid_count: got count=%0d empty=%b want 0/1", count, empty); else passed++;
    total++; if (inst !== 32'h0 || inst_valid !== 1'b0)
      $display("FAIL rstmid_inst: got inst=%h vld=%b want 0/0", inst, inst_valid); else passed++;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (inst_valid !== 1'b0 || underflow !== 1'b1)
      $display("FAIL rstmid_empty_rd: got vld=%b udf=%b want 0/1", inst_valid, underflow); else passed++;
  endtask

  initial begin
    rst = 1'b1; MDR_wr = 1'b0; MDR_rd = 1'b0; flush = 1'b0; instin = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_ovf_udf();
    do_reset();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
